// File: rtl/and3b1_deglitch_bit.sv
// Single-channel input conditioner: a free-running synchroniser chain
// followed by a consecutive-mismatch counter filter. The filtered bit only
// follows the synchronised input after FILT_LEN back-to-back enabled edges
// of disagreement, so short pulses never reach the downstream gate.
module and3b1_deglitch_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic INIT        = 1'b1,
    parameter int   CNT_W       = 2
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_ce,
    input  logic i_d,
    output logic o_q,
    output logic o_upd,
    output logic o_cntZero
);

    // Terminal count: reaching it on a mismatching edge means the new value
    // has been seen for FILT_LEN consecutive enabled edges.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   w_s;
    logic                   w_mismatch;
    logic                   w_upd;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_s != r_q);
    assign w_upd      = i_ce & w_mismatch & (r_cnt == CNT_MAX);

    // Synchroniser chain shifts every edge, independent of the filter enable.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_sync <= {SYNC_STAGES{INIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    // Filter counter: restart on agreement, count on disagreement, and
    // accept the synchronised value once the terminal count is reached.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_q   <= INIT;
            r_cnt <= '0;
        end else if (i_ce) begin
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_q   <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_q       = r_q;
    assign o_upd     = w_upd;
    assign o_cntZero = (r_cnt == '0);

endmodule

// File: rtl/and3b1_input_deglitch.sv
// Three-channel synchronise-and-deglitch stage feeding an AND3B1 gate.
// Q resets to INIT (I0 high by default) so the inverted-I0 input of the gate
// holds its output low until the inputs have been qualified.
module and3b1_input_deglitch #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 4,
    parameter logic [2:0] INIT        = 3'b001
) (
    input  logic       C,
    input  logic       CLRN,
    input  logic       CE,
    input  logic [2:0] D,
    output logic [2:0] Q,
    output logic       CHG,
    output logic       STABLE
);

    // Counter only has to reach FILT_LEN-1, so it can never wrap.
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [2:0] w_upd;
    logic [2:0] w_cntZero;
    logic       r_chg;

    for (genvar g = 0; g < 3; g++) begin : g_chan
        and3b1_deglitch_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .INIT        (INIT[g]),
            .CNT_W       (CNT_W)
        ) u_bit (
            .i_clk     (C),
            .i_rstN    (CLRN),
            .i_ce      (CE),
            .i_d       (D[g]),
            .o_q       (Q[g]),
            .o_upd     (w_upd[g]),
            .o_cntZero (w_cntZero[g])
        );
    end

    // One-cycle change pulse; simultaneous channel updates merge into one.
    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= |w_upd;
        end
    end

    assign CHG    = r_chg;
    assign STABLE = &w_cntZero;

endmodule

// File: doc/and3b1_input_deglitch.md
Name: and3b1_input_deglitch

Overview:
- Three-channel input conditioning stage that sits directly upstream of an AND3B1 gate instance.
- Each channel is asynchronous to C. It is synchronised, then glitch-filtered, and Q[2:0] drives the gate inputs I0, I1, I2.
- Reset state Q = INIT (default 3'b001). With I0 high at reset, the inverted-I0 input of the downstream AND3B1 forces its output low until the inputs are qualified.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per channel; legal range >= 2.
- FILT_LEN, 4: consecutive C edges a synchronised value must differ from Q before Q follows it; legal range >= 1.
- INIT, 3'b001: reset value of the synchroniser flops and of Q.

Ports:
- C  input  1  clock, rising edge.
- CLRN  input  1  reset, asynchronous, active-low.
- CE  input  1  filter clock enable; the synchronisers run regardless of CE.
- D  input  3  raw asynchronous inputs; D[0] feeds I0.
- Q  output  3  filtered outputs to AND3B1 I0, I1, I2.
- CHG  output  1  one-cycle pulse on the edge where any Q bit changes.
- STABLE  output  1  high when all filter counters are zero.

Behaviour:
- Reset:
  - CLRN low asynchronously sets every sync flop[i] to INIT[i], Q = INIT, all counters = 0 and CHG = 0.
  - STABLE = 1 while in reset.
  - Release is synchronous to C; the first update occurs on the first rising edge after CLRN goes high.
- Synchroniser: per channel, a chain of SYNC_STAGES flops that shifts every edge independent of CE. Let s[i] be the last stage.
- Filter, per channel, evaluated on each rising edge when CE = 1:
  - If s[i] == Q[i]: cnt[i] <= 0.
  - If s[i] != Q[i] and cnt[i] < FILT_LEN-1: cnt[i] <= cnt[i]+1.
  - If s[i] != Q[i] and cnt[i] == FILT_LEN-1: Q[i] <= s[i], cnt[i] <= 0.
- CE = 0: cnt and Q hold; CHG <= 0.
- FILT_LEN = 1: Q follows s on the first mismatching edge.
- Counter width is max(1, clog2(FILT_LEN)). The counter never exceeds FILT_LEN-1, so it cannot wrap.
- Latency with CE held high: D changes and stays stable; the first edge sampling the new value is edge 1. Q updates at edge SYNC_STAGES+FILT_LEN (edge 6 with defaults).
- Any pulse shorter than FILT_LEN consecutive mismatching sampled edges is discarded. Its counter restarts from 0 on the next mismatch.
- CHG: registered, equal to the OR over channels of the "Q[i] updates this edge" condition. It is high for exactly the cycle following the Q change edge.
- Simultaneous channel updates give a single one-cycle CHG.
- STABLE: combinational NOR of all counters being nonzero, i.e. high only when every cnt is zero. It may be 1 while s != Q for the cycle before the first count.
- Reset mid-qualification: all counters are discarded and Q returns to INIT immediately.
- No X propagation: every flop has a defined reset value.

Decomposition:
- No shared package. SYNC_STAGES, FILT_LEN, INIT and the counter width are parameters/localparams of the top.
- One sub-module, and3b1_deglitch_bit: a single-channel synchroniser plus counter filter.
  - Parameters: SYNC_STAGES, FILT_LEN, INIT bit.
  - Outputs: q, upd, cnt_zero.
  - The top instantiates it 3 times, ORs the upd outputs into the CHG register and ANDs the cnt_zero outputs into STABLE.

Test Plan:
- Reset: hold CLRN = 0 with D = 3'b110 -> Q = 3'b001, CHG = 0, STABLE = 1. Release CLRN, hold D = 3'b001 for 20 cycles -> Q stays 3'b001, CHG never pulses.
- Latency, defaults, CE = 1: step D from 3'b001 to 3'b110 just before edge 1 -> Q = 3'b001 through edge 5, Q = 3'b110 after edge 6, CHG high for exactly one cycle after edge 6.
- Glitch rejection: D[1] pulses high for 3 cycles and returns low -> Q[1] stays 0, CHG stays 0, STABLE returns to 1. Repeat with a 4-cycle pulse -> Q[1] toggles high, then back low after the trailing filter.
- CE gating: start a D[2] change and drop CE for 5 cycles after 2 counted edges -> Q holds. Q updates 2 edges after CE returns high.
- Independent channels: change D[0] and D[2] on the same edge -> both Q bits update on the same edge and CHG pulses once. Stagger them by 2 cycles -> two separate CHG pulses, 2 cycles apart.
- Reset mid-operation: assert CLRN low while cnt = 2 -> Q = INIT and cnt = 0 immediately, without waiting for a clock edge. After release, the full SYNC_STAGES+FILT_LEN latency applies again. Also rerun with FILT_LEN = 1 -> latency = SYNC_STAGES+1 edges.
